// File: rtl/icache_pkg.sv
// icache_pkg: shared arbiter state encodings, width defaults and index-width helper
package icache_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr, wrapping
module rr_pick
  import icache_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  assign rot = N'({req, req} >> ptr);
  assign any = |req;
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port, one transaction in flight; MEM_ARB_STATS_EN adds counters
module mem_port_arbiter
  import icache_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      mem_req_valid,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic [DATA_W-1:0]         mem_req_rdata,
  output logic [IW-1:0]             grant_id,
`ifdef MEM_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]     grant_count,
  output logic [31:0]               wait_cycles,
`endif
  output logic                      busy
);
  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  sel_addr;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(pick_grant),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) sel_addr |= pick_grant[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0;
  end
  assign busy = state == ARB_BUSY;
  assign req_ready = (busy && mem_req_ready) ? NUM_REQ'(1) << grant_id : '0;
  assign req_rdata = mem_req_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
    end else if (state == ARB_IDLE) begin
      if (pick_any) begin
        grant_id <= pick_idx;
        mem_req_addr <= sel_addr;
        mem_req_valid <= 1'b1;
        state <= ARB_BUSY;
      end
    end else if (state == ARB_BUSY) begin
      if (mem_req_ready) begin
        mem_req_valid <= 1'b0;
        rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
        state <= ARB_DONE;
      end
    end else begin
      state <= ARB_IDLE;
    end
  end
`ifdef MEM_ARB_STATS_EN
  logic [NUM_REQ-1:0] owned;
  assign owned = busy ? NUM_REQ'(1) << grant_id : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count <= '0;
      wait_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && grant_count[i*32 +: 32] != '1) grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
      if (|(req_valid & ~owned) && wait_cycles != '1) wait_cycles <= wait_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the round-robin memory port arbiter
module tb_mem_port_arbiter;
  logic        clk = 0;
  logic        reset = 0;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 0;
  logic [31:0] mem_req_rdata = '0;
  logic [0:0]  grant_id;
  logic        busy;
`ifdef MEM_ARB_STATS_EN
  logic [63:0] grant_count;
  logic [31:0] wait_cycles;
`endif
  int checks = 0;
  int errors = 0;
  int pulses[2];
  typedef struct {logic [31:0] addr; logic id;} exp_t;
  exp_t exp_q[$];

  mem_port_arbiter dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .req_rdata(req_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_req_rdata(mem_req_rdata),
    .grant_id(grant_id),
`ifdef MEM_ARB_STATS_EN
    .grant_count(grant_count),
    .wait_cycles(wait_cycles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1;
    tick;
    reset = 0;
    pulses[0] = 0;
    pulses[1] = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic id);
    exp_t e;
    e.addr = a;
    e.id = id;
    exp_q.push_back(e);
  endtask

  // waits for a grant, checks it against the scoreboard, then answers after lat cycles
  task automatic serve(input int lat, input logic [31:0] data, output int waited);
    exp_t e;
    logic [1:0] want;
    waited = 0;
    while (!mem_req_valid && waited < 20) begin
      tick;
      waited++;
    end
    checks++;
    if (!mem_req_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL grant_wait valid=%0b queued=%0d required valid=1 with queued>0", mem_req_valid, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    want = 2'b01 << e.id;
    checks++;
    if (mem_req_addr !== e.addr) begin
      errors++;
      $display("FAIL mem_addr got=%h want=%h", mem_req_addr, e.addr);
    end
    checks++;
    if (grant_id !== e.id || busy !== 1'b1) begin
      errors++;
      $display("FAIL grant_id got=%0d busy=%0b want=%0d busy=1", grant_id, busy, e.id);
    end
    for (int i = 0; i < lat; i++) begin
      tick;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== e.addr || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL busy_hold valid=%0b addr=%h ready=%b want valid=1 addr=%h ready=00", mem_req_valid, mem_req_addr, req_ready, e.addr);
      end
    end
    mem_req_ready = 1;
    mem_req_rdata = data;
    #1;
    checks++;
    if (req_ready !== want || req_rdata !== data) begin
      errors++;
      $display("FAIL resp ready=%b rdata=%h want ready=%b rdata=%h", req_ready, req_rdata, want, data);
    end
    if (req_ready === want) pulses[e.id]++;
    @(posedge clk);
    #1;
    mem_req_ready = 0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL done_state valid=%0b busy=%0b ready=%b want 0 0 00", mem_req_valid, busy, req_ready);
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0 || req_ready !== 2'b00 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset valid=%0b busy=%0b gid=%0d ready=%b addr=%h want all zero", mem_req_valid, busy, grant_id, req_ready, mem_req_addr);
    end
  endtask

  task automatic test_single;
    int w;
    req_addr[31:0] = 32'h0000_0040;
    req_valid = 2'b01;
    push(32'h40, 1'b0);
    serve(3, 32'hDEAD_BEEF, w);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (mem_req_valid !== 1'b0 || req_ready !== 2'b00 || grant_id !== 1'b0) begin
        errors++;
        $display("FAIL single_idle valid=%0b ready=%b gid=%0d want 0 00 0", mem_req_valid, req_ready, grant_id);
      end
    end
  endtask

  task automatic test_back_to_back;
    int w;
    do_reset;
    req_addr = {32'h200, 32'h100};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) push(i[0] ? 32'h200 : 32'h100, i[0]);
    for (int i = 0; i < 4; i++) begin
      serve(0, 32'hA000_0000 + i, w);
      if (i > 0) begin
        checks++;
        if (w !== 2) begin
          errors++;
          $display("FAIL spacing gap=%0d want=2", w);
        end
      end
    end
    req_valid = 2'b00;
    tick;
    tick;
  endtask

  task automatic test_owner_drop;
    int w;
    req_addr[63:32] = 32'h300;
    req_valid = 2'b10;
    push(32'h300, 1'b1);
    tick;
    req_valid = 2'b00;
    req_addr[63:32] = 32'h999;
    serve(2, 32'h1234_5678, w);
    tick;
    checks++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0 || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL drop_idle busy=%0b valid=%0b gid=%0d want 0 0 1", busy, mem_req_valid, grant_id);
    end
  endtask

  task automatic test_reset_mid_busy;
    int w;
    req_addr[31:0] = 32'h500;
    req_valid = 2'b01;
    push(32'h500, 1'b0);
    serve(0, 32'h0BAD_F00D, w);
    tick;
    tick;
    checks++;
    if (busy !== 1'b1 || mem_req_addr !== 32'h500) begin
      errors++;
      $display("FAIL regrant busy=%0b addr=%h want 1 500", busy, mem_req_addr);
    end
    do_reset;
    req_valid = 2'b00;
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy valid=%0b busy=%0b gid=%0d want 0 0 0", mem_req_valid, busy, grant_id);
    end
    mem_req_ready = 1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL late_ready ready=%b want 00", req_ready);
    end
    tick;
    mem_req_ready = 0;
    req_addr = {32'h600, 32'h700};
    req_valid = 2'b11;
    push(32'h700, 1'b0);
    serve(0, 32'h1, w);
    req_valid = 2'b00;
    tick;
  endtask

  task automatic test_spurious;
    tick;
    mem_req_ready = 1;
    mem_req_rdata = 32'hFFFF_0000;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL spurious_ready ready=%b want 00", req_ready);
    end
    tick;
    mem_req_ready = 0;
    checks++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_state busy=%0b valid=%0b want 0 0", busy, mem_req_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_owner_drop;
    test_reset_mid_busy;
    test_spurious;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
`ifdef MEM_ARB_STATS_EN
    checks++;
    if (grant_count !== {pulses[1][31:0], pulses[0][31:0]}) begin
      errors++;
      $display("FAIL grant_count got=%h want=%h", grant_count, {pulses[1][31:0], pulses[0][31:0]});
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
